axil_regfile_slave: RTL and testbench
=====================================

Name: axil_regfile_slave

Overview:
- Parametrised AXI4-Lite register-file slave; next generation of the fixed 32x32-bit demo slave.
- Decouples AW and W acceptance and holds B and R responses stable under master backpressure.
- Returns SLVERR for out-of-range and read-only targets; supports configurable register count, data width and a read-only mask.
- Sits behind the interconnect; register contents are exported flat for fabric logic.

Parameters:
C_S_AXI_DATA_WIDTH, 32, data width in bits; 32 or 64.
NUM_REGS, 24, number of implemented registers; 1..2^(C_S_AXI_ADDR_WIDTH-ADDR_LSB).
C_S_AXI_ADDR_WIDTH, 7, byte address width.
ADDR_LSB, derived clog2(C_S_AXI_DATA_WIDTH/8), low address bits ignored (2 for 32-bit).
RO_MASK, 0, NUM_REGS-bit mask; bit i set makes register i read-only.

Ports:
S_AXI_ACLK  in  1  clock, all logic on rising edge
S_AXI_ARESET  in  1  asynchronous active-high reset
S_AXI_AWVALID  in  1  write address valid
S_AXI_AWREADY  out  1  write address ready
S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write byte address
S_AXI_AWPROT  in  3  ignored
S_AXI_WVALID  in  1  write data valid
S_AXI_WREADY  out  1  write data ready
S_AXI_WDATA  in  C_S_AXI_DATA_WIDTH  write data
S_AXI_WSTRB  in  C_S_AXI_DATA_WIDTH/8  byte strobes
S_AXI_BVALID  out  1  write response valid
S_AXI_BREADY  in  1  write response ready
S_AXI_BRESP  out  2  00 OKAY, 10 SLVERR
S_AXI_ARVALID  in  1  read address valid
S_AXI_ARREADY  out  1  read address ready
S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read byte address
S_AXI_ARPROT  in  3  ignored
S_AXI_RVALID  out  1  read data valid
S_AXI_RREADY  in  1  read data ready
S_AXI_RDATA  out  C_S_AXI_DATA_WIDTH  read data
S_AXI_RRESP  out  2  00 OKAY, 10 SLVERR
regs_out  out  NUM_REGS*C_S_AXI_DATA_WIDTH  flat register contents; reg i at bits [i*DW +: DW]

Behaviour:
- Reset (asynchronous assert, any cycle including mid-transaction):
  - Clears aw_held, w_held, BVALID, RVALID, BRESP, RRESP and RDATA to 0 and all registers to 0.
  - Drops pending transactions; no response is issued for them.
- Write address buffer:
  - One entry. AWREADY = !aw_held. An AW handshake stores index = AWADDR[AW-1:ADDR_LSB] and sets aw_held.
- Write data buffer:
  - One entry. WREADY = !w_held. A W handshake stores WDATA/WSTRB and sets w_held.
  - AW and W may arrive in either order or in the same cycle.
- Commit condition: aw_held && w_held && (!BVALID || BREADY). On commit:
  - Clear both held flags and set BVALID.
  - If index >= NUM_REGS or RO_MASK[index]: no register change, BRESP=10.
  - Otherwise update only the byte lanes with WSTRB set and return BRESP=00. WSTRB=0 gives OKAY with no change.
- Write latency: AW+W handshake at edge N -> commit at edge N+1 -> BVALID visible after edge N+1. Peak rate is one write per 2 cycles.
- B channel: BVALID/BRESP hold until BREADY. A new commit may coincide with the BREADY-accepted cycle.
- Read channel:
  - ARREADY = !RVALID || RREADY (combinational).
  - An AR handshake registers RDATA = reg[index] and RRESP=00, or RDATA=0 and RRESP=10 when index >= NUM_REGS. Read-only registers read normally with OKAY.
  - RVALID is set one cycle after the handshake. Back-to-back reads run at full rate while RREADY=1.
  - RDATA/RRESP are stable while RVALID && !RREADY.
- Read/write collision: a read handshake in the same cycle as a commit to the same register returns the pre-write value.
- Address low bits [ADDR_LSB-1:0] are ignored; unaligned addresses alias to the containing word.
- regs_out reflects the register state after each edge, with no extra latency.

Test Plan:
- Reset, then AW(0x00)+W(0xDEADBEEF, strb 1111) in the same cycle with BREADY=1 -> BVALID one cycle after the commit with BRESP=00. Read 0x00 -> RDATA=0xDEADBEEF, RRESP=00, RVALID one cycle after AR.
- W(0x80000000, strb 1000) three cycles before AW(0x04) -> WREADY low while held, single BVALID after AW. reg1=0x80000000; read 0x07 aliases to the same value.
- Write to 0x60 (index 24) and read 0x7C -> BRESP=10 with no register change; RDATA=0, RRESP=10.
- RO_MASK=0x4, write 0x08 with 0x1234 -> BRESP=10, reg2 stays 0; read 0x08 -> RRESP=00.
- Two writes with BREADY=0 for 5 cycles -> BVALID/BRESP stable; second AW/W accepted but not committed until BREADY=1; both responses delivered in order.
- Read issued with RREADY=0 for 4 cycles -> RDATA stable and ARREADY=0. Reset asserted mid-wait -> RVALID=0 immediately and no response after release.

Source files
------------

// File: rtl/axil_regfile_slave_if.sv
// axil_regfile_slave_if: AXI4-Lite channel bundle between a master and the register-file slave.
interface axil_regfile_slave_if #(parameter int DW = 32, parameter int AW = 7);
  logic          awvalid, awready;
  logic [AW-1:0] awaddr;
  logic [2:0]    awprot;
  logic          wvalid, wready;
  logic [DW-1:0] wdata;
  logic [DW/8-1:0] wstrb;
  logic          bvalid, bready;
  logic [1:0]    bresp;
  logic          arvalid, arready;
  logic [AW-1:0] araddr;
  logic [2:0]    arprot;
  logic          rvalid, rready;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  modport master (
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready, arvalid, araddr, arprot, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
  modport slave (
    input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready, arvalid, araddr, arprot, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/axil_regfile_slave.sv
// axil_regfile_slave: AXI4-Lite register file with decoupled AW/W buffers, SLVERR on bad or read-only targets.
module axil_regfile_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int NUM_REGS = 24,
  parameter int C_S_AXI_ADDR_WIDTH = 7,
  parameter int ADDR_LSB = $clog2(C_S_AXI_DATA_WIDTH/8),
  parameter logic [NUM_REGS-1:0] RO_MASK = '0
) (
  input  logic S_AXI_ACLK,
  input  logic S_AXI_ARESET,
  axil_regfile_slave_if.slave s_axi,
  output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] regs_out
);
  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int SW = DW/8;
  localparam int IW = C_S_AXI_ADDR_WIDTH - ADDR_LSB;
  localparam logic [2**IW-1:0] RO_FULL = (2**IW)'(RO_MASK);
  logic [NUM_REGS-1:0][DW-1:0] regs;
  logic aw_held, w_held, commit, wr_bad, rd_bad, ar_hs;
  logic [IW-1:0] aw_idx, ar_idx;
  logic [DW-1:0] w_data, rd_word;
  logic [SW-1:0] w_strb;
  logic unused_bits;
  assign unused_bits = ^{s_axi.awprot, s_axi.arprot, s_axi.awaddr[ADDR_LSB-1:0], s_axi.araddr[ADDR_LSB-1:0]};
  assign regs_out = regs;
  assign s_axi.awready = !aw_held;
  assign s_axi.wready = !w_held;
  assign s_axi.arready = !s_axi.rvalid || s_axi.rready;
  assign ar_hs = s_axi.arvalid && s_axi.arready;
  assign ar_idx = s_axi.araddr[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB];
  assign commit = aw_held && w_held && (!s_axi.bvalid || s_axi.bready);
  assign wr_bad = ({1'b0, aw_idx} >= (IW+1)'(NUM_REGS)) || RO_FULL[aw_idx];
  assign rd_bad = {1'b0, ar_idx} >= (IW+1)'(NUM_REGS);
  // Out-of-range indices match no register, so the mux yields zero for them.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++) rd_word = (ar_idx == IW'(i)) ? regs[i] : rd_word;
  end
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET)
    if (S_AXI_ARESET) begin
      aw_held <= 1'b0;
      w_held <= 1'b0;
      aw_idx <= '0;
      w_data <= '0;
      w_strb <= '0;
      s_axi.bvalid <= 1'b0;
      s_axi.bresp <= 2'b00;
      regs <= '0;
    end else begin
      if (s_axi.awvalid && !aw_held) begin
        aw_held <= 1'b1;
        aw_idx <= s_axi.awaddr[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB];
      end
      if (s_axi.wvalid && !w_held) begin
        w_held <= 1'b1;
        w_data <= s_axi.wdata;
        w_strb <= s_axi.wstrb;
      end
      if (commit) begin
        aw_held <= 1'b0;
        w_held <= 1'b0;
        s_axi.bvalid <= 1'b1;
        s_axi.bresp <= wr_bad ? 2'b10 : 2'b00;
      end else if (s_axi.bready) s_axi.bvalid <= 1'b0;
      if (commit && !wr_bad)
        for (int i = 0; i < NUM_REGS; i++)
          for (int b = 0; b < SW; b++)
            if (aw_idx == IW'(i) && w_strb[b]) regs[i][b*8 +: 8] <= w_data[b*8 +: 8];
    end
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET)
    if (S_AXI_ARESET) begin
      s_axi.rvalid <= 1'b0;
      s_axi.rdata <= '0;
      s_axi.rresp <= 2'b00;
    end else if (ar_hs) begin
      s_axi.rvalid <= 1'b1;
      s_axi.rdata <= rd_word;
      s_axi.rresp <= rd_bad ? 2'b10 : 2'b00;
    end else if (s_axi.rready) s_axi.rvalid <= 1'b0;
endmodule

// File: tb/tb_axil_regfile_slave.sv
// tb_axil_regfile_slave: random and directed AXI4-Lite traffic checked by a queue scoreboard against an array model.
module tb_axil_regfile_slave;
  localparam logic [23:0] RO = 24'h000004;
  logic clk, rst, rnd_bp;
  logic [24*32-1:0] regs_out;
  int checks = 0, failures = 0;
  logic [1:0]  b_q[$];
  logic [33:0] r_q[$];
  logic [31:0] mem [24];

  axil_regfile_slave_if #(.DW(32), .AW(7)) s();
  axil_regfile_slave #(.C_S_AXI_DATA_WIDTH(32), .NUM_REGS(24), .C_S_AXI_ADDR_WIDTH(7), .RO_MASK(RO)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESET(rst), .s_axi(s), .regs_out(regs_out));

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void flag(input string name);
    checks++;
    failures++;
    $display("FAIL %s at %0t", name, $time);
  endfunction

  function automatic logic [1:0] model_write(input logic [6:0] addr, input logic [31:0] data, input logic [3:0] strb);
    int idx;
    idx = int'(addr) / 4;
    if (idx >= 24) return 2'b10;
    if (RO[idx]) return 2'b10;
    for (int b = 0; b < 4; b++) if (strb[b]) mem[idx][8*b +: 8] = data[8*b +: 8];
    return 2'b00;
  endfunction

  function automatic logic [33:0] model_read(input logic [6:0] addr);
    int idx;
    idx = int'(addr) / 4;
    return (idx >= 24) ? {2'b10, 32'h0} : {2'b00, mem[idx]};
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 24; i++) mem[i] = '0;
  endfunction

  // Monitor: pops the scoreboard on every completed response and checks stability under backpressure.
  initial begin
    logic pb, pr;
    logic [1:0] pb_resp;
    logic [33:0] pr_val;
    pb = 0; pr = 0; pb_resp = 0; pr_val = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pb = 0; pr = 0;
      end else begin
        if (pb) chk("b_stable", {s.bvalid, s.bresp}, {1'b1, pb_resp});
        if (pr) chk("r_stable", {s.rvalid, s.rresp, s.rdata}, {1'b1, pr_val});
        if (s.bvalid && s.bready) begin
          if (b_q.size() == 0) flag("b_unexpected");
          else chk("bresp", s.bresp, b_q.pop_front());
        end
        if (s.rvalid && s.rready) begin
          if (r_q.size() == 0) flag("r_unexpected");
          else chk("rresp_rdata", {s.rresp, s.rdata}, r_q.pop_front());
        end
        pb = s.bvalid && !s.bready; pb_resp = s.bresp;
        pr = s.rvalid && !s.rready; pr_val = {s.rresp, s.rdata};
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rnd_bp) begin
        s.bready = 1'($urandom_range(0, 1));
        s.rready = 1'($urandom_range(0, 1));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic axi_write(input logic [6:0] addr, input logic [31:0] data, input logic [3:0] strb, input int lead);
    bit aw_done, w_done;
    int cyc;
    aw_done = 0; w_done = 0; cyc = 0;
    s.awaddr = addr; s.wdata = data; s.wstrb = strb; s.wvalid = 1; s.awvalid = (lead == 0);
    while (!(aw_done && w_done) && cyc < 100) begin
      @(negedge clk);
      if (w_done && !aw_done) chk("wready_held", s.wready, 0);
      if (s.awvalid && s.awready) aw_done = 1;
      if (s.wvalid && s.wready) w_done = 1;
      @(posedge clk); #1;
      cyc++;
      if (aw_done) s.awvalid = 0; else if (cyc >= lead) s.awvalid = 1;
      if (w_done) s.wvalid = 0;
    end
    s.awvalid = 0; s.wvalid = 0;
    if (aw_done && w_done) b_q.push_back(model_write(addr, data, strb));
    else flag("write_timeout");
  endtask

  task automatic axi_read(input logic [6:0] addr);
    bit done;
    int cyc;
    done = 0; cyc = 0;
    s.araddr = addr; s.arvalid = 1;
    while (!done && cyc < 100) begin
      @(negedge clk);
      done = s.arready;
      @(posedge clk); #1;
      cyc++;
    end
    s.arvalid = 0;
    if (done) r_q.push_back(model_read(addr));
    else flag("read_timeout");
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((b_q.size() != 0 || r_q.size() != 0) && n < 300) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (b_q.size() != 0 || r_q.size() != 0) begin
      flag("drain_timeout");
      b_q.delete();
      r_q.delete();
    end
  endtask

  initial begin
    logic [31:0] old3;
    rst = 1; rnd_bp = 0;
    s.awvalid = 0; s.awaddr = 0; s.awprot = 0; s.wvalid = 0; s.wdata = 0; s.wstrb = 0;
    s.bready = 1; s.arvalid = 0; s.araddr = 0; s.arprot = 0; s.rready = 1;
    model_clear();
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_awready", s.awready, 1);
    chk("rst_wready", s.wready, 1);
    chk("rst_arready", s.arready, 1);
    chk("rst_bvalid", s.bvalid, 0);
    chk("rst_rvalid", s.rvalid, 0);
    chk("rst_bresp", s.bresp, 0);
    chk("rst_rresp_rdata", {s.rresp, s.rdata}, 0);
    for (int i = 0; i < 24; i++) chk($sformatf("rst_reg%0d", i), regs_out[i*32 +: 32], 0);
    @(posedge clk); #1;

    // Same-cycle AW+W, then response and read latency.
    axi_write(7'h00, 32'hDEADBEEF, 4'hF, 0);
    @(negedge clk); chk("b_not_early", s.bvalid, 0);
    @(negedge clk); chk("b_latency", s.bvalid, 1);
    @(posedge clk); #1;
    wait_idle();
    axi_read(7'h00);
    @(negedge clk); chk("r_latency", s.rvalid, 1);
    @(posedge clk); #1;
    wait_idle();

    // W leads AW by three cycles; unaligned read aliases.
    axi_write(7'h04, 32'h80000000, 4'h8, 3);
    wait_idle();
    axi_read(7'h07);
    wait_idle();

    // Out-of-range and read-only targets.
    axi_write(7'h60, 32'h55AA55AA, 4'hF, 0);
    wait_idle();
    axi_read(7'h7C);
    axi_write(7'h08, 32'h00001234, 4'hF, 0);
    wait_idle();
    axi_read(7'h08);
    wait_idle();
    chk("ro_reg2", regs_out[2*32 +: 32], 0);

    // Two writes under B backpressure.
    s.bready = 0;
    old3 = mem[3];
    axi_write(7'h60, 32'h1, 4'hF, 0);
    axi_write(7'h0C, 32'hA5A5A5A5, 4'hF, 0);
    repeat (5) begin
      @(negedge clk);
      chk("bp_bvalid", s.bvalid, 1);
      chk("bp_reg3_uncommitted", regs_out[3*32 +: 32], old3);
    end
    @(posedge clk); #1;
    s.bready = 1;
    wait_idle();
    chk("bp_reg3_committed", regs_out[3*32 +: 32], 32'hA5A5A5A5);

    // Read held under R backpressure, then reset mid-wait drops it.
    s.rready = 0;
    axi_read(7'h00);
    repeat (4) begin
      @(negedge clk);
      chk("rbp_rvalid", s.rvalid, 1);
      chk("rbp_arready", s.arready, 0);
    end
    @(posedge clk); #1;
    rst = 1;
    #1;
    chk("async_rst_rvalid", s.rvalid, 0);
    chk("async_rst_reg0", regs_out[31:0], 0);
    b_q.delete();
    r_q.delete();
    model_clear();
    repeat (2) @(posedge clk);
    #1 rst = 0; s.rready = 1;
    repeat (5) begin
      @(negedge clk);
      chk("post_rst_rvalid", s.rvalid, 0);
      chk("post_rst_bvalid", s.bvalid, 0);
    end
    @(posedge clk); #1;

    // Random traffic with random backpressure.
    rnd_bp = 1;
    repeat (80) begin
      if ($urandom_range(0, 2) == 0) begin
        wait_idle();
        axi_read(7'($urandom_range(0, 127)));
      end else begin
        axi_write(7'($urandom_range(0, 127)), $urandom, 4'($urandom_range(0, 15)), int'($urandom_range(0, 2)));
      end
    end
    rnd_bp = 0;
    @(posedge clk); #2;
    s.bready = 1; s.rready = 1;
    wait_idle();
    for (int i = 0; i < 24; i++) chk($sformatf("final_reg%0d", i), regs_out[i*32 +: 32], mem[i]);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
